// File: rtl/sram_1w1r_fifo_ctrl.sv
// sram_1w1r_fifo_ctrl
//  Streaming FIFO controller in front of a 1W1R SRAM macro (both macro clocks tied to clk).
//  Pushes are written through port 0. Reads are prefetched through port 1 into a 2-entry
//  output buffer that drives out_valid/out_data.
//  Optional feature macro: FIFO_BYPASS_EN. When it is defined, a push into an otherwise
//  empty pipeline goes straight to the output buffer.
// Ports
//  clk, rst_n              clock, asynchronous active-low reset
//  in_valid/in_ready/in_data     push interface
//  out_valid/out_ready/out_data  pop interface (out_data = head of FIFO)
//  level                   words held: SRAM + read in flight + output buffer
//  sram_csb0/wmask0/addr0/din0   macro write port (csb active low)
//  sram_csb1/addr1/dout1         macro read port (dout1 valid the cycle after issue)
module sram_1w1r_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 96,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DEPTH      = 38,
   parameter int unsigned NUM_WMASKS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [6:0]            level,
   output logic                  sram_csb0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned LVL_W = 7;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      sram_cnt_q, sram_cnt_d;
   logic                  rd_inflight_q, rd_inflight_d;
   logic [1:0]            ob_cnt_q, ob_cnt_d;
   logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
   logic [DATA_WIDTH-1:0] ob1_q, ob1_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;

   logic                  push, pop, bypass, wr_en, rd_issue, load;
   logic [1:0]            ob_base;
   logic [DATA_WIDTH-1:0] load_data;

   // Handshakes, read issue and output-buffer bookkeeping
   always_comb begin
      push      = in_valid & in_ready_q;
      pop       = out_valid_q & out_ready;
      // Issue only if the buffer still has a free slot for the returning word after this pop.
      rd_issue  = (sram_cnt_q != '0) &&
                  ((3'({1'b0, ob_cnt_q}) + 3'(rd_inflight_q)) < (3'd2 + 3'(pop)));
`ifdef FIFO_BYPASS_EN
      bypass    = push && (sram_cnt_q == '0) && !rd_inflight_q &&
                  (3'({1'b0, ob_cnt_q}) < (3'd2 + 3'(pop)));
`else
      bypass    = 1'b0;
`endif
      wr_en     = push & ~bypass;
      load      = rd_inflight_q | bypass;
      load_data = rd_inflight_q ? sram_dout1 : in_data;

      wr_ptr_d = wr_ptr_q;
      if (wr_en) begin
         wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      end
      rd_ptr_d = rd_ptr_q;
      if (rd_issue) begin
         rd_ptr_d = (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
      end

      sram_cnt_d    = sram_cnt_q + CNT_W'(wr_en) - CNT_W'(rd_issue);
      rd_inflight_d = rd_issue;
      ob_cnt_d      = ob_cnt_q + 2'(load) - 2'(pop);
      level_d       = level_q + LVL_W'(push) - LVL_W'(pop);
      in_ready_d    = (sram_cnt_d < CNT_W'(DEPTH));
      out_valid_d   = (ob_cnt_d != 2'd0);

      // Shift-style buffer: ob0 is the head, a new word lands in the first free slot.
      ob_base = ob_cnt_q - 2'(pop);
      ob0_d   = ob0_q;
      ob1_d   = ob1_q;
      if (pop) begin
         ob0_d = ob1_q;
      end
      if (load) begin
         if (ob_base == 2'd0) begin
            ob0_d = load_data;
         end else begin
            ob1_d = load_data;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         sram_cnt_q    <= '0;
         rd_inflight_q <= 1'b0;
         ob_cnt_q      <= 2'd0;
         ob0_q         <= '0;
         ob1_q         <= '0;
         level_q       <= '0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         sram_cnt_q    <= sram_cnt_d;
         rd_inflight_q <= rd_inflight_d;
         ob_cnt_q      <= ob_cnt_d;
         ob0_q         <= ob0_d;
         ob1_q         <= ob1_d;
         level_q       <= level_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
      end
   end

   // Macro ports are same-cycle strobes; status outputs come straight from flops
   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = ob0_q;
   assign level       = level_q;
   assign sram_csb0   = ~wr_en;
   assign sram_wmask0 = '1;
   assign sram_addr0  = wr_ptr_q;
   assign sram_din0   = in_data;
   assign sram_csb1   = ~rd_issue;
   assign sram_addr1  = rd_ptr_q;

endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// Testbench for sram_1w1r_fifo_ctrl: behavioural 1W1R macro, cycle table for the
// single-word pipeline, scoreboard on every pop, plus fill/drain/stream/reset sequences.
module tb_sram_1w1r_fifo_ctrl;

   localparam int unsigned DW = 96;
   localparam int unsigned AW = 6;
   localparam int unsigned DEPTH = 38;
   localparam int unsigned NV = 10;
   localparam logic [DW-1:0] DA = {12{8'hA5}};
   localparam logic [DW-1:0] DB = {12{8'hB6}};
   localparam logic [DW-1:0] DC = {12{8'hC7}};

   logic          clk, rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data, sram_din0, sram_dout1;
   logic [6:0]    level;
   logic          sram_csb0, sram_csb1;
   logic [2:0]    sram_wmask0;
   logic [AW-1:0] sram_addr0, sram_addr1;

   int            checks = 0;
   int            failures = 0;
   int            n_push = 0;
   logic [DW-1:0] sb[$];
   logic [AW-1:0] rd_log[$];
   logic [DW-1:0] mem[0:63];

   sram_1w1r_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level),
      .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
      .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
      .sram_dout1(sram_dout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Macro model: synchronous write, synchronous read (data valid the following cycle)
   always @(posedge clk) begin
      if (!sram_csb0) mem[sram_addr0] <= sram_din0;
      if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard and macro-port monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            sb.push_back(in_data);
            n_push++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_unexpected actual=%0h expected=none", out_data);
            end else begin
               chk("pop_data", out_data, sb.pop_front());
            end
         end
         if (!sram_csb0) begin
            chk("wr_addr_range", 128'(sram_addr0 < AW'(DEPTH)), 128'(1));
            chk("wmask", sram_wmask0, 128'h7);
         end
         if (!sram_csb1) begin
            rd_log.push_back(sram_addr1);
            chk("rd_addr_range", 128'(sram_addr1 < AW'(DEPTH)), 128'(1));
         end
         if (!sram_csb0 && !sram_csb1)
            chk("rw_same_addr", 128'(sram_addr0 == sram_addr1), 128'(0));
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      next_cycle();
      sb.delete();
      rd_log.delete();
      n_push = 0;
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (level == 7'd0) break;
         next_cycle();
      end
      next_cycle();
      chk({name, "_level"}, level, 0);
      chk({name, "_sb_empty"}, sb.size(), 0);
      chk({name, "_out_valid"}, out_valid, 0);
   endtask

   typedef struct {
      logic          in_valid;
      logic [DW-1:0] in_data;
      logic          out_ready;
      logic          exp_in_ready;
      logic          exp_out_valid;
      logic [DW-1:0] exp_data;
      logic [6:0]    exp_level;
      logic          exp_csb0;
      logic          exp_csb1;
      logic [AW-1:0] exp_addr0;
      logic [AW-1:0] exp_addr1;
   } vec_t;

   vec_t vecs[NV];

   initial begin
      // Single-word latency and a 3-word stall/pop pattern from reset, one row per cycle
      vecs[0] = '{1'b1, DA, 1'b1, 1'b1, 1'b0, '0, 7'd0, 1'b0, 1'b1, 6'd0, 6'd0};
      vecs[1] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 7'd1, 1'b1, 1'b0, 6'd1, 6'd0};
      vecs[2] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 7'd1, 1'b1, 1'b1, 6'd1, 6'd1};
      vecs[3] = '{1'b1, DB, 1'b0, 1'b1, 1'b1, DA, 7'd1, 1'b0, 1'b1, 6'd1, 6'd1};
      vecs[4] = '{1'b1, DC, 1'b0, 1'b1, 1'b1, DA, 7'd2, 1'b0, 1'b0, 6'd2, 6'd1};
      vecs[5] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, DA, 7'd3, 1'b1, 1'b1, 6'd3, 6'd2};
      vecs[6] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, DA, 7'd3, 1'b1, 1'b0, 6'd3, 6'd2};
      vecs[7] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, DB, 7'd2, 1'b1, 1'b1, 6'd3, 6'd3};
      vecs[8] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, DC, 7'd1, 1'b1, 1'b1, 6'd3, 6'd3};
      vecs[9] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 7'd0, 1'b1, 1'b1, 6'd3, 6'd3};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_csb0", sram_csb0, 1);
      chk("rst_csb1", sram_csb1, 1);
      rst_n = 1'b1;

      for (int i = 0; i < int'(NV); i++) begin
         in_valid  = vecs[i].in_valid;
         in_data   = vecs[i].in_data;
         out_ready = vecs[i].out_ready;
         #1;
         chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_in_ready);
         chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_out_valid);
         chk($sformatf("v%0d_level", i), level, vecs[i].exp_level);
         chk($sformatf("v%0d_csb0", i), sram_csb0, vecs[i].exp_csb0);
         chk($sformatf("v%0d_csb1", i), sram_csb1, vecs[i].exp_csb1);
         chk($sformatf("v%0d_addr0", i), sram_addr0, vecs[i].exp_addr0);
         chk($sformatf("v%0d_addr1", i), sram_addr1, vecs[i].exp_addr1);
         if (vecs[i].exp_out_valid)
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
         next_cycle();
      end

      // Fill with output stalled: 38 in SRAM + 2 in output buffer
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 50; c++) begin
         in_valid = 1'b1;
         in_data  = {$urandom(), $urandom(), $urandom()};
         next_cycle();
      end
      in_valid = 1'b0;
      #1;
      chk("fill_accepted", n_push, 40);
      chk("fill_level", level, 40);
      chk("fill_in_ready", in_ready, 0);
      chk("fill_out_valid", out_valid, 1);

      // One pop frees a slot via a read issue; in_ready follows one cycle later
      out_ready = 1'b1;
      #1;
      chk("free_read_issue", sram_csb1, 0);
      chk("free_ready_same_cycle", in_ready, 0);
      next_cycle();
      out_ready = 1'b0;
      #1;
      chk("free_ready_next_cycle", in_ready, 1);
      chk("free_level", level, 39);

      drain("fill_drain");
      chk("rd_seq_len", rd_log.size(), 40);
      for (int i = 0; i < rd_log.size() && i < 40; i++)
         chk($sformatf("rd_seq_%0d", i), rd_log[i], 128'(i % int'(DEPTH)));

      // Continuous push and pop: no bubble after priming, constant level
      out_ready = 1'b1;
      n_push = 0;
      for (int c = 0; c < 200; c++) begin
         in_valid = 1'b1;
         in_data  = {$urandom(), $urandom(), $urandom()};
         #1;
         if (c >= 3) begin
            chk($sformatf("stream_valid_%0d", c), out_valid, 1);
            chk($sformatf("stream_level_%0d", c), level, 3);
         end
         next_cycle();
      end
      chk("stream_pushes", n_push, 200);
      drain("stream_drain");

      // Reset while a read is in flight
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = DB;
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("mid_read_issue", sram_csb1, 0);
      next_cycle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_level", level, 0);
      next_cycle();
      sb.delete();
      rd_log.delete();
      rst_n = 1'b1;
      next_cycle();
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_level", level, 0);
      in_valid = 1'b1;
      in_data  = DC;
      next_cycle();
      drain("post_rst_drain");
      chk("post_rst_reads", rd_log.size(), 1);
      if (rd_log.size() > 0) chk("post_rst_addr1", rd_log[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
